canvas_reader: RTL and testbench
================================

# canvas_reader

Streams the 28x28 drawing canvas out as a row-major sequence of 16-bit pixels over a valid/ready handshake. It is the read-side counterpart of the canvas editor, which writes the canvas array. It sits between the canvas array and any serial consumer, such as a serial-input neural-network layer or a debug dump path. One scan is launched per `Start` pulse, and the block also reports the total ink sum of the frame.

## Interface
Parameters:
- `DIM`, default 28 — canvas width and height in pixels.
- `PIX_W`, default 16 — pixel width in bits.
- `SUM_W`, default 26 — ink-sum accumulator width; 784·65535 < 2^26.

Ports:
- `Clk` input 1 — sole clock.
- `Reset_n` input 1 — synchronous, active-low reset.
- `Start` input 1 — begin a scan; sampled only in IDLE.
- `Abort` input 1 — terminate the scan and return to IDLE; no `Done` is issued.
- `canvas` input [PIX_W-1:0] [DIM-1:0][DIM-1:0] — indexed `canvas[row][col]`.
- `Pix_Data` output PIX_W — current pixel.
- `Pix_Index` output 10 — linear index, `row*DIM+col`.
- `Pix_Last` output 1 — high with the final pixel, index 783.
- `Pix_Valid` output 1 — `Pix_Data`, `Pix_Index` and `Pix_Last` are valid.
- `Pix_Ready` input 1 — consumer accepts the pixel.
- `Busy` output 1 — scan in progress.
- `Done` output 1 — one-cycle pulse after the last transfer.
- `Ink_Sum` output SUM_W — sum of all transferred pixels; stable from `Done` until the next `Start`.

## Operation
- States:
  - IDLE: `Busy`=0, `Pix_Valid`=0.
  - SCAN: `Busy`=1, `Pix_Valid`=1.
  - DONE: one cycle, `Done`=1.
- Transitions:
  - IDLE→SCAN on `Start`=1. `row`, `col` and `Ink_Sum` clear to 0.
  - SCAN→DONE on a transfer with `Pix_Last`=1.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on `Abort`=1. `Abort` has priority over a same-cycle transfer and over `Start`.
- Transfer condition: `Pix_Valid && Pix_Ready`.
- On each transfer:
  - `Ink_Sum += Pix_Data`, zero-extended.
  - `col` increments. When `col` wraps at DIM-1 it returns to 0 and `row` increments.
  - `Pix_Index` increments by 1.
- Stall behaviour: while `Pix_Valid`=1 and `Pix_Ready`=0, all outputs hold.
- `Pix_Data` selects `canvas[row][col]` through a registered mux.
- `Start` is ignored in SCAN and DONE; there is no queuing.
- `Start` and `Abort` together in IDLE: the block remains in IDLE.
- `Ink_Sum` after `Abort`: holds the partial sum and is undefined for use. No `Done` is issued.

## Timing
- Reset (`Reset_n`=0 at a clock edge):
  - state IDLE
  - `Pix_Valid`, `Busy`, `Done` and `Pix_Last` = 0
  - `Pix_Data`, `Pix_Index` and `Ink_Sum` = 0.
- Reset mid-scan behaves identically to the above. Reset takes priority over everything.
- Start latency: `Start` at edge N gives `Pix_Valid`=1 with pixel 0 from edge N+1.
- Throughput: one pixel per cycle with `Pix_Ready` held high. A full scan is therefore 784 SCAN cycles, `Done` on cycle 785 after `Start`, and IDLE on cycle 786.
- Output registering: `Pix_Data`, `Pix_Index` and `Pix_Last` are registered. After a transfer at edge K, the next pixel is valid at edge K+1.
- `Pix_Valid` never drops in SCAN without an `Abort` or `Reset_n`.

## Configuration
- Macro: `CANVAS_READER_SNAPSHOT_EN`.
- When defined:
  - On IDLE→SCAN, the full canvas is copied into an internal register array.
  - Pixels are read from that copy, so edits made during a scan do not appear.
  - The sum and stream reflect the frame as it was at `Start`.
- When undefined:
  - Pixels are read live from `canvas` at the moment the output register loads.
  - Edits made mid-scan appear for pixels not yet read.
  - No snapshot storage is built.

## Structure
- Package `canvas_pkg`:
  - `CANVAS_DIM`=28, `PIX_W`=16, `NUM_PIX`=784
  - `pixel_t` (logic [PIX_W-1:0])
  - `canvas_t` (pixel_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0])
  - enum `reader_state_e` {IDLE, SCAN, DONE}.
- Sub-module `raster_counter`:
  - Holds the row/col/index counters with `advance` and `clear` inputs and a `last` output.
  - Reusable by the editor and VGA-side logic.

## Test plan
- Canvas with `canvas[r][c] = r*28+c`, `Pix_Ready`=1, `Start` pulse → indices 0..783 with data equal to index, `Pix_Last` only at 783, `Done` on cycle 785, `Ink_Sum`=306936.
- Same canvas, `Pix_Ready` toggling on a 3-on/2-off pattern → identical data sequence, outputs held on every stall cycle, same `Ink_Sum`.
- All pixels 16'hFFFF → `Ink_Sum` = 784·65535 = 51379440, with no overflow.
- `Abort` at index 100 → next cycle IDLE, `Pix_Valid`=0, no `Done`; a subsequent `Start` restarts at index 0.
- `Start` re-asserted during SCAN, and `Reset_n`=0 at index 400 → the re-`Start` is ignored; reset gives all outputs 0 and IDLE on the next cycle.
- With the macro on: change `canvas[27][27]` to 5 after `Start` → streamed pixel 783 keeps its old value. With the macro off → pixel 783 reads 5.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, pixel/canvas types and the reader FSM encoding.
package canvas_pkg;

  localparam int unsigned CANVAS_DIM = 28;
  localparam int unsigned PIX_W      = 16;
  localparam int unsigned NUM_PIX    = CANVAS_DIM * CANVAS_DIM;
  localparam int unsigned IDX_W      = 10;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [CANVAS_DIM-1:0][CANVAS_DIM-1:0] canvas_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } reader_state_e;

endpackage

// File: rtl/canvas_reader_if.sv
// Pixel stream valid/ready bundle between the canvas reader and its consumer.
interface canvas_reader_if #(
  parameter int unsigned PIX_W = 16,
  parameter int unsigned IDX_W = 10
);

  logic [PIX_W-1:0] Pix_Data;
  logic [IDX_W-1:0] Pix_Index;
  logic             Pix_Last;
  logic             Pix_Valid;
  logic             Pix_Ready;

  modport master (
    output Pix_Data,
    output Pix_Index,
    output Pix_Last,
    output Pix_Valid,
    input  Pix_Ready
  );

  modport slave (
    input  Pix_Data,
    input  Pix_Index,
    input  Pix_Last,
    input  Pix_Valid,
    output Pix_Ready
  );

endinterface

// File: rtl/raster_counter.sv
// Row-major raster position counter (row, col, linear index) with clear/advance.
// Exposes next-cycle row/col so a registered pixel mux can load in step with it.
module raster_counter #(
  parameter int unsigned DIM   = 28,
  parameter int unsigned IDX_W = 10,
  localparam int unsigned RC_W = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [RC_W-1:0]  row_c,
  output logic [RC_W-1:0]  col_c,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  localparam int unsigned LAST_IDX = DIM * DIM - 1;

  logic [RC_W-1:0]  row_q;
  logic [RC_W-1:0]  col_q;
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] index_d;
  logic             last_q;

  // Next position: clear wins over advance; col wraps into row, index wraps at frame end.
  always_comb begin
    row_c   = row_q;
    col_c   = col_q;
    index_d = index_q;
    if (clear) begin
      row_c   = '0;
      col_c   = '0;
      index_d = '0;
    end else if (advance) begin
      if (col_q == RC_W'(DIM - 1)) begin
        col_c = '0;
        row_c = (row_q == RC_W'(DIM - 1)) ? '0 : row_q + RC_W'(1);
      end else begin
        col_c = col_q + RC_W'(1);
      end
      index_d = (index_q == IDX_W'(LAST_IDX)) ? '0 : index_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      row_q   <= row_c;
      col_q   <= col_c;
      index_q <= index_d;
      last_q  <= (index_d == IDX_W'(LAST_IDX));
    end
  end

  assign index = index_q;
  assign last  = last_q;

endmodule

// File: rtl/canvas_reader.sv
// Streams the canvas row-major over valid/ready and accumulates the frame ink sum.
// Define CANVAS_READER_SNAPSHOT_EN to stream a copy of the canvas captured at Start.
module canvas_reader #(
  parameter int unsigned DIM   = canvas_pkg::CANVAS_DIM,
  parameter int unsigned PIX_W = canvas_pkg::PIX_W,
  parameter int unsigned SUM_W = 26
) (
  input  logic                                  Clk,
  input  logic                                  Reset_n,
  input  logic                                  Start,
  input  logic                                  Abort,
  input  logic [DIM-1:0][DIM-1:0][PIX_W-1:0]    canvas,
  canvas_reader_if.master                       pix,
  output logic                                  Busy,
  output logic                                  Done,
  output logic [SUM_W-1:0]                      Ink_Sum
);

  import canvas_pkg::*;

  localparam int unsigned RC_W = $clog2(DIM);

  reader_state_e    state_q;
  reader_state_e    state_d;
  logic             valid_q;
  logic             valid_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic [PIX_W-1:0] data_q;
  logic [PIX_W-1:0] data_d;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  logic             clear_c;
  logic             advance_c;
  logic             load_c;
  logic             xfer_c;
  logic             last_c;
  logic [RC_W-1:0]  row_c;
  logic [RC_W-1:0]  col_c;
  logic [PIX_W-1:0] src_pix_c;

  raster_counter #(
    .DIM   (DIM),
    .IDX_W (IDX_W)
  ) u_raster (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clear   (clear_c),
    .advance (advance_c),
    .row_c   (row_c),
    .col_c   (col_c),
    .index   (pix.Pix_Index),
    .last    (last_c)
  );

`ifdef CANVAS_READER_SNAPSHOT_EN
  logic [DIM-1:0][DIM-1:0][PIX_W-1:0] snap_q;

  // Frame copy taken on scan launch; pixel 0 is read live since the copy lands that edge.
  always_ff @(posedge Clk) begin
    if (clear_c) begin
      snap_q <= canvas;
    end
  end

  assign src_pix_c = clear_c ? canvas[row_c][col_c] : snap_q[row_c][col_c];
`else
  assign src_pix_c = canvas[row_c][col_c];
`endif

  assign xfer_c = valid_q & pix.Pix_Ready;

  // Next-state and next-output logic; Abort outranks both Start and a transfer.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    clear_c   = 1'b0;
    advance_c = 1'b0;
    load_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          state_d = SCAN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          sum_d   = '0;
          clear_c = 1'b1;
          load_c  = 1'b1;
        end
      end
      SCAN: begin
        if (Abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer_c) begin
          sum_d = sum_q + SUM_W'(data_q);
          if (last_c) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            advance_c = 1'b1;
            load_c    = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    data_d = load_c ? src_pix_c : data_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  assign pix.Pix_Valid = valid_q;
  assign pix.Pix_Data  = data_q;
  assign pix.Pix_Last  = last_c;
  assign Busy          = busy_q;
  assign Done          = done_q;
  assign Ink_Sum       = sum_q;

endmodule

// File: tb/tb_canvas_reader.sv
// Self-checking bench for canvas_reader: frame-level reference model plus directed and random scans.
module tb_canvas_reader;

  localparam int DIM = 28;
  localparam int NP  = DIM * DIM;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            rst_n;
  logic                            start;
  logic                            abort;
  logic [DIM-1:0][DIM-1:0][15:0]   canvas;
  logic                            busy;
  logic                            done;
  logic [25:0]                     ink_sum;

  canvas_reader_if #(.PIX_W(16), .IDX_W(10)) rd ();

  canvas_reader #(.DIM(DIM), .PIX_W(16), .SUM_W(26)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .Start   (start),
    .Abort   (abort),
    .canvas  (canvas),
    .pix     (rd.master),
    .Busy    (busy),
    .Done    (done),
    .Ink_Sum (ink_sum)
  );

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame as a flat pixel list, scan position, running sum.
  bit     m_act, m_done, m_was_done, m_zero;
  int     m_pos, m_data;
  longint m_sum;
  int     snap[NP];

  function automatic int pix_at(input int p);
`ifdef CANVAS_READER_SNAPSHOT_EN
    return snap[p];
`else
    return int'(canvas[p / DIM][p % DIM]);
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_done = 0; m_zero = 1; m_pos = 0; m_sum = 0; m_data = 0;
    end else begin
      m_was_done = m_done;
      m_done = 0;
      if (m_act) begin
        if (abort) m_act = 0;
        else if (rd.Pix_Ready) begin
          m_sum += m_data;
          if (m_pos == NP - 1) begin
            m_act = 0;
            m_done = 1;
          end else begin
            m_pos++;
            m_data = pix_at(m_pos);
          end
        end
      end else if (!m_was_done && start && !abort) begin
        for (int i = 0; i < NP; i++) snap[i] = int'(canvas[i / DIM][i % DIM]);
        m_act = 1; m_zero = 0; m_pos = 0; m_sum = 0;
        m_data = pix_at(0);
      end
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("valid", 64'(rd.Pix_Valid), 64'(m_act));
      chk("busy", 64'(busy), 64'(m_act));
      chk("done", 64'(done), 64'(m_done));
      if (m_act) begin
        chk("data", 64'(rd.Pix_Data), 64'(m_data));
        chk("index", 64'(rd.Pix_Index), 64'(m_pos));
        chk("last", 64'(rd.Pix_Last), 64'(m_pos == NP - 1));
        chk("sum_run", 64'(ink_sum), m_sum);
      end
      if (m_done) chk("sum_done", 64'(ink_sum), m_sum);
      if (m_zero) begin
        chk("zero_data", 64'(rd.Pix_Data), 0);
        chk("zero_index", 64'(rd.Pix_Index), 0);
        chk("zero_last", 64'(rd.Pix_Last), 0);
        chk("zero_sum", 64'(ink_sum), 0);
      end
    end
  end

  // Consumer ready: 0 = always, 1 = 3-on/2-off, 2 = random.
  int rdy_mode = 0;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    phase++;
    case (rdy_mode)
      0:       rd.Pix_Ready = 1'b1;
      1:       rd.Pix_Ready = ((phase % 5) < 3);
      default: rd.Pix_Ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) canvas[r][c] = 16'(r * DIM + c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!done && cycles < 4000) begin
      cyc();
      cycles++;
    end
    chk("done_seen", 64'(done), 1);
  endtask

  task automatic run_scan(output int cycles);
    pulse_start();
    wait_done(cycles);
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (!(rd.Pix_Valid && int'(rd.Pix_Index) == target) && n < 4000) begin
      cyc();
      n++;
    end
    chk("reach_idx", 64'(n < 4000), 1);
  endtask

  int cycles;
  int exp_edit;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    fill_ramp();
    cyc();
    run_chk = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_valid", 64'(rd.Pix_Valid), 0);
    chk("rst_sum", 64'(ink_sum), 0);

    // Ramp frame, consumer always ready.
    rdy_mode = 0;
    run_scan(cycles);
    chk("done_cycle", 64'(cycles), 785);
    chk("ramp_sum", 64'(ink_sum), 306936);
    cyc();
    chk("idle_after_done", 64'(busy | rd.Pix_Valid | done), 0);

    // Same frame with 3-on/2-off stalls.
    rdy_mode = 1;
    run_scan(cycles);
    chk("stall_sum", 64'(ink_sum), 306936);
    cyc();

    // Full-scale frame, random ready.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) canvas[r][c] = 16'hFFFF;
    rdy_mode = 2;
    run_scan(cycles);
    chk("max_sum", 64'(ink_sum), 51379440);
    cyc();

    // Abort at index 100, then restart.
    fill_ramp();
    rdy_mode = 0;
    pulse_start();
    wait_idx(100);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_valid", 64'(rd.Pix_Valid), 0);
    chk("abort_busy", 64'(busy), 0);
    repeat (5) cyc();
    pulse_start();
    chk("restart_idx", 64'(rd.Pix_Index), 0);
    chk("restart_valid", 64'(rd.Pix_Valid), 1);
    wait_done(cycles);
    chk("restart_sum", 64'(ink_sum), 306936);
    cyc();

    // Re-Start during scan is ignored; reset at index 400 clears everything.
    pulse_start();
    wait_idx(200);
    pulse_start();
    chk("restart_ignored", 64'(rd.Pix_Index), 201);
    wait_idx(400);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(rd.Pix_Valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_data", 64'(rd.Pix_Data), 0);
    chk("mid_rst_index", 64'(rd.Pix_Index), 0);
    chk("mid_rst_sum", 64'(ink_sum), 0);

    // Start together with Abort in IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'(rd.Pix_Valid), 0);
    cyc();

    // Edit of the final pixel after launch.
    pulse_start();
    canvas[27][27] = 16'd5;
`ifdef CANVAS_READER_SNAPSHOT_EN
    exp_edit = 783;
`else
    exp_edit = 5;
`endif
    wait_idx(783);
    chk("edit_px783", 64'(rd.Pix_Data), 64'(exp_edit));
    wait_done(cycles);
    cyc();

    // Random frames with random stalls, stray Starts and occasional Aborts.
    for (int it = 0; it < 6; it++) begin
      int n;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) canvas[r][c] = 16'($urandom);
      rdy_mode = 2;
      pulse_start();
      n = 0;
      while ((busy || done) && n < 4000) begin
        abort = ($urandom_range(0, 499) == 0);
        start = ($urandom_range(0, 30) == 0);
        if (($urandom_range(0, 99) == 0)) canvas[$urandom_range(0, 27)][$urandom_range(0, 27)] = 16'($urandom);
        cyc();
        n++;
      end
      abort = 1'b0;
      start = 1'b0;
      chk("rand_end", 64'(n < 4000), 1);
      repeat (2) cyc();
    end

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
